// File: rtl/des_key_schedule_iter_if.sv
// Request/response bundle between a DES key-schedule client and the
// iterative key schedule; the master side is the client.
interface des_key_schedule_iter_if;
  logic         start;
  logic [63:0]  key;
  logic         decrypt;
  logic         busy;
  logic         done;
  logic [767:0] round_keys;

  modport master (
    output start, key, decrypt,
    input  busy, done, round_keys
  );

  modport slave (
    input  start, key, decrypt,
    output busy, done, round_keys
  );
endinterface

// File: rtl/des_key_schedule_iter.sv
// Iterative DES key schedule: PC-1 on accept, then one rotate+PC-2 round
// per cycle, packing K1..K16 (or reversed for decrypt) into round_keys.
module des_key_schedule_iter (
  input logic                     clk,
  input logic                     rst_n,
  des_key_schedule_iter_if.slave  ks
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // DES bit numbering: bit 1 is the MSB, so bit b of x[N-1:0] is x[N-b]
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++)
      r[6'(55 - i)] = k[6'(64 - PC1[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++)
      r[6'(47 - i)] = cd[6'(56 - PC2[i])];
    return r;
  endfunction

  state_e       state_q, state_d;
  logic [27:0]  c_q, c_d;
  logic [27:0]  d_q, d_d;
  logic [4:0]   rnd_q, rnd_d;
  logic         dec_q, dec_d;
  logic [767:0] rk_q, rk_d;

  logic         two;
  logic [27:0]  cn, dn;
  logic [47:0]  kn;
  logic [55:0]  cd0;
  logic [4:0]   slot;
  logic [9:0]   base;

  assign two  = !(rnd_q inside {5'd1, 5'd2, 5'd9, 5'd16});
  assign cn   = two ? {c_q[25:0], c_q[27:26]} : {c_q[26:0], c_q[27]};
  assign dn   = two ? {d_q[25:0], d_q[27:26]} : {d_q[26:0], d_q[27]};
  assign kn   = pc2({cn, dn});
  assign cd0  = pc1(ks.key);
  assign slot = dec_q ? 5'd17 - rnd_q : rnd_q;
  // slot s occupies the s-th 48-bit field counted from the MSB
  assign base = 10'd815 - 10'(slot) * 10'd48;

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    rnd_d   = rnd_q;
    dec_d   = dec_q;
    rk_d    = rk_q;
    unique case (state_q)
      IDLE: begin
        if (ks.start) begin
          c_d     = cd0[55:28];
          d_d     = cd0[27:0];
          dec_d   = ks.decrypt;
          rnd_d   = 5'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        c_d = cn;
        d_d = dn;
        rnd_d = rnd_q + 5'd1;
        rk_d[base -: 48] = kn;
        if (rnd_q == 5'd16)
          state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      rnd_q   <= '0;
      dec_q   <= 1'b0;
      rk_q    <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      rnd_q   <= rnd_d;
      dec_q   <= dec_d;
      rk_q    <= rk_d;
    end
  end

  assign ks.busy       = (state_q != IDLE);
  assign ks.done       = (state_q == DONE);
  assign ks.round_keys = rk_q;

endmodule

// File: tb/tb_des_key_schedule_iter.sv
// Bench for des_key_schedule_iter: scoreboard of reference schedules
// built from the key, compared whenever done pulses.
module tb_des_key_schedule_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  des_key_schedule_iter_if ks ();

  des_key_schedule_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ks    (ks)
  );

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;

  localparam int T_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int T_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int T_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int cyc = 0;
  logic [767:0] sb [$];

  always @(posedge clk) cyc++;
  always @(negedge clk) if (ks.done === 1'b1) done_cnt++;

  function automatic logic [55:0] m_pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55 - i] = k[64 - T_PC1[i]];
    return r;
  endfunction

  function automatic logic [47:0] m_pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47 - i] = cd[56 - T_PC2[i]];
    return r;
  endfunction

  function automatic logic [27:0] m_rot(input logic [27:0] x, input int t);
    logic [55:0] w;
    w = {x, x};
    return w[55 - t -: 28];
  endfunction

  // Each Kn is derived directly from C0/D0 by the cumulative rotation
  function automatic logic [767:0] model_rk(input logic [63:0] k,
                                            input logic dec);
    logic [55:0] cd0;
    logic [767:0] r;
    int tot, slot;
    cd0 = m_pc1(k);
    r = '0;
    tot = 0;
    for (int n = 0; n < 16; n++) begin
      tot += T_SH[n];
      slot = dec ? 15 - n : n;
      r[767 - 48 * slot -: 48] =
        m_pc2({m_rot(cd0[55:28], tot % 28), m_rot(cd0[27:0], tot % 28)});
    end
    return r;
  endfunction

  task automatic run_sched(input logic [63:0] k, input logic dec,
                           input bit toggle, input bit pulse,
                           output logic [767:0] got);
    int cnt;
    bit seen;
    logic [767:0] exp;
    logic [55:0] cd0;
    cd0 = m_pc1(k);
    ks.key = k;
    ks.decrypt = dec;
    ks.start = 1'b1;
    sb.push_back(model_rk(k, dec));
    cnt = 0;
    seen = 0;
    got = '0;
    while (!seen && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (ks.done === 1'b1) seen = 1;
      ks.start = (pulse && !seen) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (toggle) begin
        ks.key = ~ks.key;
        ks.decrypt = ~ks.decrypt;
      end
    end
    exp = sb.pop_front();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: got no done in %0d cycles want 17", cnt);
    end else begin
      got = ks.round_keys;
      checks++;
      if (cnt != 17) begin
        errors++;
        $display("FAIL latency: got %0d want 17", cnt);
      end
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL round_keys: got %h want %h", got, exp);
      end
      checks++;
      if (ks.busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_at_done: got %b want 1", ks.busy);
      end
      checks++;
      if ({dut.c_q, dut.d_q} !== cd0) begin
        errors++;
        $display("FAIL cd_wrap: got %h want %h", {dut.c_q, dut.d_q}, cd0);
      end
    end
    ks.key = k;
    ks.decrypt = dec;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ks.start = 1'b0;
    ks.key = '0;
    ks.decrypt = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({ks.busy, ks.done} !== 2'b00 || ks.round_keys !== '0) begin
        errors++;
        $display("FAIL reset_idle: got busy=%b done=%b rk_nz=%b want 0 0 0",
                 ks.busy, ks.done, |ks.round_keys);
      end
    end
  endtask

  task automatic test_encrypt();
    logic [767:0] g;
    run_sched(KEY_A, 1'b0, 0, 0, g);
    checks++;
    if (g[767:720] !== 48'h1B02EFFC7072) begin
      errors++;
      $display("FAIL enc_slot1: got %h want 1b02effc7072", g[767:720]);
    end
    checks++;
    if (g[719:672] !== 48'h79AED9DBC9E5) begin
      errors++;
      $display("FAIL enc_slot2: got %h want 79aed9dbc9e5", g[719:672]);
    end
    checks++;
    if (g[47:0] !== 48'hCB3D8B0E17F5) begin
      errors++;
      $display("FAIL enc_slot16: got %h want cb3d8b0e17f5", g[47:0]);
    end
  endtask

  task automatic test_decrypt();
    logic [767:0] g;
    run_sched(KEY_A, 1'b1, 0, 0, g);
    checks++;
    if (g[767:720] !== 48'hCB3D8B0E17F5) begin
      errors++;
      $display("FAIL dec_slot1: got %h want cb3d8b0e17f5", g[767:720]);
    end
    checks++;
    if (g[95:48] !== 48'h79AED9DBC9E5) begin
      errors++;
      $display("FAIL dec_slot15: got %h want 79aed9dbc9e5", g[95:48]);
    end
    checks++;
    if (g[47:0] !== 48'h1B02EFFC7072) begin
      errors++;
      $display("FAIL dec_slot16: got %h want 1b02effc7072", g[47:0]);
    end
  endtask

  task automatic test_zero_and_toggle();
    logic [767:0] g, ref_g;
    run_sched(64'h0, 1'b0, 0, 0, g);
    checks++;
    if (g !== '0) begin
      errors++;
      $display("FAIL zero_key: got %h want 0", g);
    end
    run_sched(64'h0101010101010101, 1'b0, 0, 0, g);
    checks++;
    if (g !== '0) begin
      errors++;
      $display("FAIL parity_key: got %h want 0", g);
    end
    ref_g = model_rk(KEY_A, 1'b0);
    run_sched(KEY_A, 1'b0, 1, 0, g);
    checks++;
    if (g !== ref_g) begin
      errors++;
      $display("FAIL key_toggle: got %h want %h", g, ref_g);
    end
  endtask

  task automatic test_start_ignored();
    logic [767:0] g;
    int d0;
    d0 = done_cnt;
    run_sched(KEY_B, 1'b0, 0, 1, g);
    repeat (25) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || ks.busy !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored: got dones=%0d busy=%b want 1 0",
               done_cnt - d0, ks.busy);
    end
  endtask

  task automatic test_back_to_back();
    int t [3];
    int n, guard;
    logic [767:0] exp;
    ks.key = KEY_B;
    ks.decrypt = 1'b1;
    ks.start = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back(model_rk(KEY_B, 1'b1));
    n = 0;
    guard = 0;
    while (n < 3 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (ks.done === 1'b1) begin
        t[n] = cyc;
        exp = sb.pop_front();
        checks++;
        if (ks.round_keys !== exp) begin
          errors++;
          $display("FAIL b2b_keys%0d: got %h want %h", n, ks.round_keys, exp);
        end
        n++;
        if (n == 3) ks.start = 1'b0;
      end
    end
    ks.start = 1'b0;
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d dones want 3", n);
      while (sb.size() > 0) void'(sb.pop_front());
    end else begin
      checks++;
      if (t[1] - t[0] != 18 || t[2] - t[1] != 18) begin
        errors++;
        $display("FAIL b2b_period: got %0d %0d want 18 18",
                 t[1] - t[0], t[2] - t[1]);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (ks.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop: got busy=%b want 0", ks.busy);
    end
  endtask

  task automatic test_reset_abort();
    logic [767:0] g;
    int d0;
    d0 = done_cnt;
    ks.key = KEY_B;
    ks.decrypt = 1'b0;
    ks.start = 1'b1;
    @(negedge clk);
    ks.start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ks.busy, ks.done} !== 2'b00 || ks.round_keys !== '0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b rk_nz=%b want 0 0 0",
               ks.busy, ks.done, |ks.round_keys);
    end
    checks++;
    if (dut.rnd_q !== 5'd0 || {dut.c_q, dut.d_q} !== 56'h0) begin
      errors++;
      $display("FAIL reset_regs: got rnd=%0d cd=%h want 0 0",
               dut.rnd_q, {dut.c_q, dut.d_q});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_sched(KEY_B, 1'b0, 0, 0, g);
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL abort_no_done: got dones=%0d want 1", done_cnt - d0);
    end
  endtask

  initial begin
    ks.start = 1'b0;
    ks.key = '0;
    ks.decrypt = 1'b0;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_zero_and_toggle();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/des_key_schedule_iter.md
# des_key_schedule_iter

Iterative DES key schedule feeding the fully unrolled encryption datapath. It accepts a 64-bit key and applies PC-1. It then generates K1..K16 at one round per cycle, using left rotations followed by PC-2, and packs them into the 768-bit `round_keys` bus that the encryption core consumes. A decrypt option stores the keys in reverse order so that the same encryption core performs DES decryption.

## Interface
- No parameters; all widths are fixed by DES.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active low.
- `start`  input  1  request; sampled only in IDLE; `key` and `decrypt` are valid in the same cycle.
- `key`  input  [1:64]  DES key, bit 1 = MSB; parity bits 8,16,…,64 are ignored (dropped by PC-1).
- `decrypt`  input  1  0: K1 in slot 1; 1: K16 in slot 1 (reversed order).
- `busy`  output  1  high in RUN and DONE.
- `done`  output  1  one-cycle pulse; `round_keys` is complete and valid.
- `round_keys`  output  [1:768]  slot s (1..16) = bits [48(s-1)+1 : 48s], concatenated in the format expected by the encryption core.

## Operation
- Registers:
  - C and D, 28 bits each.
  - 5-bit round counter `rnd`.
  - `dec_q` flag.
  - 768-bit key register driving `round_keys`.
  - State register.
- IDLE:
  - `busy`=0, `done`=0.
  - On `start`=1: C,D <= PC-1(`key`) halves (C0,D0); `dec_q` <= `decrypt`; `rnd` <= 1; go to RUN.
  - On `start`=0: stay in IDLE.
- RUN, with `rnd`=n:
  - Rotation amount r = 1 for n ∈ {1,2,9,16}; r = 2 otherwise.
  - Cn = C rotated left by r; Dn = D rotated left by r (28-bit rotate, wrap MSB into LSB).
  - Kn = PC-2(Cn‖Dn), written into slot n (`dec_q`=0) or slot 17−n (`dec_q`=1).
  - C,D <= Cn,Dn; `rnd` <= n+1.
  - When n=16: write K16 and go to DONE.
  - Total rotation after 16 rounds is 28, so C16=C0 and D16=D0. This is a self-check available to the verifier.
- DONE:
  - `done`=1 for exactly this one cycle.
  - Next state is IDLE unconditionally.
- `start` is ignored in RUN and DONE; there is no queueing.
- `key` and `decrypt` are sampled only on the accepting edge. Later changes have no effect on the current schedule.
- `round_keys`:
  - Holds its value from DONE until the next accepted `start`.
  - During RUN the bus is partially updated and not valid for consumers.
  - Slots not yet rewritten keep their previous values.
- Reset at any point returns to IDLE and clears all registers, aborting any schedule in progress with no `done` pulse.

## Timing
- Reset values: `busy`=0, `done`=0, `round_keys`=768'h0; state=IDLE; C=D=0; `rnd`=0; `dec_q`=0.
- `start` accepted on edge t. Slot writes happen on edges t+1 through t+16; DONE is entered on edge t+16.
- `done`=1 during the cycle after edge t+16, i.e. 17 cycles after the accepting cycle.
- Back-to-back operation: with `start` held high, a new schedule is accepted in the IDLE cycle following DONE, giving a period of 18 cycles.
- `done` and `busy` are Moore outputs decoded from registered state, with no combinational path from inputs.
- Consumer rule: assert the encryption core's `start` only at or after `done`, and never while `busy`=1 and not `done`.

## Test plan
- Reset, then idle for 5 cycles with `start`=0 → `busy`=0, `done`=0, `round_keys`=0 throughout.
- Key 0x133457799BBCDFF1, `decrypt`=0 → `done` exactly 17 cycles after accept. Required slot values:
  - [1:48]=0x1B02EFFC7072
  - [49:96]=0x79AED9DBC9E5
  - [721:768]=0xCB3D8B0E17F5
  - internal C,D equal C0,D0 at DONE.
- Same key, `decrypt`=1 → [1:48]=0xCB3D8B0E17F5, [673:720]=0x79AED9DBC9E5, [721:768]=0x1B02EFFC7072.
- Keys 0x0000000000000000 and then 0x0101010101010101 (parity bits only) → both give `round_keys`=0. Then apply 0x133457799BBCDFF1 and toggle `key` every cycle during RUN → result identical to the first keyed run.
- Pulse `start` repeatedly during RUN and DONE → ignored; a single `done` per accepted `start`. With `start` held high → `done` pulses every 18 cycles.
- Assert `rst_n`=0 at round 8 → `busy`, `done`, `round_keys` go to 0 immediately (asynchronously). Release and start a new key → correct full schedule with nominal latency.
